xor_frame_stream: RTL



---
 rtl/xor_pkg.sv | 11 +
 rtl/xor_frame_stream_if.sv | 27 ++
 rtl/xor_word.sv | 11 +
 rtl/xor_frame_stream.sv | 57 +++++
 4 files changed

// File: rtl/xor_pkg.sv
// xor_pkg: shared mode encodings and width helper for the xor frame stream
package xor_pkg;
  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/xor_frame_stream_if.sv
// xor_frame_stream_if: operand input and result output stream bundle
interface xor_frame_stream_if import xor_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
);
  localparam int CW = clog2_min1(FRAME_LEN);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             invert;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_parity;
  logic             out_last;
  logic [CW-1:0]    beat_idx;
  modport master (
    output in_valid, in_a, in_b, invert, flush, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_last, beat_idx
  );
  modport slave (
    input  in_valid, in_a, in_b, invert, flush, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_last, beat_idx
  );
endinterface

// File: rtl/xor_word.sv
// xor_word: combinational per-beat XOR/XNOR of two operands
module xor_word import xor_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert,
  output logic [WIDTH-1:0] y
);
  assign y = (invert == MODE_XNOR) ? ~(a ^ b) : (a ^ b);
endmodule

// File: rtl/xor_frame_stream.sv
// xor_frame_stream: registered XOR/XNOR stream with running per-frame parity
module xor_frame_stream import xor_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input logic              clk,
  input logic              rst_n,
  xor_frame_stream_if.slave bus
);
  localparam int CW = clog2_min1(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  logic [CW-1:0]    cnt_q, cnt_d, cnt_eff, idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_eff, word, data_q, data_d, par_q, par_d;
  logic             valid_q, valid_d, last_q, last_d, accept, at_last;
  xor_word #(.WIDTH(WIDTH)) u_word (
    .a(bus.in_a), .b(bus.in_b), .invert(bus.invert), .y(word)
  );
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // flush zeroes the frame state before the same-cycle beat sees it
  always_comb begin
    cnt_eff = bus.flush ? '0 : cnt_q;
    acc_eff = bus.flush ? '0 : acc_q;
    at_last = (cnt_eff == LAST);
    cnt_d   = accept ? (at_last ? '0 : cnt_eff + 1'b1) : cnt_eff;
    acc_d   = accept ? (at_last ? '0 : acc_eff ^ word) : acc_eff;
    valid_d = accept ? 1'b1 : (bus.out_ready ? 1'b0 : valid_q);
    data_d  = accept ? word : data_q;
    par_d   = accept ? acc_eff ^ word : par_q;
    idx_d   = accept ? cnt_eff : idx_q;
    last_d  = accept ? at_last : last_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      par_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.out_parity = par_q;
  assign bus.beat_idx   = idx_q;
  assign bus.out_last   = last_q;
endmodule
